// File: rtl/tt_slot_sequencer.sv
// Upstream driver for one project-wrapper slot: sequences OFF/RESET/RUN, divides the
// project clock, drives the registered input bus and gates the registered return bus.
module tt_slot_sequencer #(
    parameter int RST_CYCLES = 8,
    parameter int DIV_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [7:0]       ui_in,
    input  logic [7:0]       uio_in,
    output logic             ena,
    output logic [17:0]      iw,
    input  logic [23:0]      ow,
    output logic [7:0]       uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe,
    output logic             running,
    output logic [1:0]       state_dbg
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pclk_q, pclk_d;
    logic [DIV_W-1:0] divcnt_q, divcnt_d;
    logic [RC_W-1:0]  rstcnt_q, rstcnt_d;
    logic             ena_q, ena_d;
    logic             running_q, running_d;
    logic [17:0]      iw_q, iw_d;
    logic [23:0]      ret_q, ret_d;

    always_comb begin
        state_d  = state_q;
        pclk_d   = pclk_q;
        divcnt_d = divcnt_q;
        rstcnt_d = rstcnt_q;
        if (cmd_stop) begin
            state_d  = ST_OFF;
            pclk_d   = 1'b0;
            divcnt_d = '0;
            rstcnt_d = '0;
        end else if (cmd_start) begin
            state_d  = ST_RESET;
            pclk_d   = 1'b0;
            divcnt_d = '0;
            rstcnt_d = '0;
        end else if (state_q != ST_OFF) begin
            if (divcnt_q == clk_div) begin
                pclk_d   = ~pclk_q;
                divcnt_d = '0;
                // Count rising edges; release reset only on a falling update.
                if (state_q == ST_RESET) begin
                    if (!pclk_q) begin
                        rstcnt_d = rstcnt_q + RC_W'(1);
                    end else if (rstcnt_q == RC_W'(RST_CYCLES)) begin
                        state_d = ST_RUN;
                    end
                end
            end else begin
                divcnt_d = divcnt_q + DIV_W'(1);
            end
        end

        ena_d     = (state_d != ST_OFF);
        running_d = (state_d == ST_RUN);
        iw_d      = ena_d ? {uio_in, ui_in, running_d, pclk_d} : 18'd0;
        // Return data only passes while the slot is running.
        ret_d     = running_d ? ow : 24'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_OFF;
            pclk_q    <= 1'b0;
            divcnt_q  <= '0;
            rstcnt_q  <= '0;
            ena_q     <= 1'b0;
            running_q <= 1'b0;
            iw_q      <= '0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            pclk_q    <= pclk_d;
            divcnt_q  <= divcnt_d;
            rstcnt_q  <= rstcnt_d;
            ena_q     <= ena_d;
            running_q <= running_d;
            iw_q      <= iw_d;
            ret_q     <= ret_d;
        end
    end

    assign ena       = ena_q;
    assign iw        = iw_q;
    assign uo_out    = ret_q[7:0];
    assign uio_out   = ret_q[15:8];
    assign uio_oe    = ret_q[23:16];
    assign running   = running_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tt_slot_sequencer.sv
// Randomized bench for tt_slot_sequencer: a slot-level reference model feeds an expected
// queue, a monitor pops and compares every cycle and also checks the reset-release rules.
module tb_tt_slot_sequencer;

    localparam int RST_CYCLES = 8;
    localparam int W          = 45;

    // Handshake: every driven cycle pushes exactly one expected entry at the negedge;
    // the monitor pops one entry 1 time unit after the following posedge.

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start, cmd_stop;
    logic [3:0]  clk_div;
    logic [7:0]  ui_in, uio_in;
    logic        ena;
    logic [17:0] iw;
    logic [23:0] ow;
    logic [7:0]  uo_out, uio_out, uio_oe;
    logic        running;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0=off, 1=reset, 2=run.
    int m_mode  = 0;
    int m_pclk  = 0;
    int m_div   = 0;
    int m_rises = 0;

    always #5 clk = ~clk;

    tt_slot_sequencer #(.RST_CYCLES(RST_CYCLES), .DIV_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .clk_div(clk_div), .ui_in(ui_in), .uio_in(uio_in), .ena(ena), .iw(iw),
        .ow(ow), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .running(running), .state_dbg(state_dbg)
    );

    function automatic logic [43:0] observed();
        return {ena, iw, uio_oe, uio_out, uo_out, running};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode  = 0;
        m_pclk  = 0;
        m_div   = 0;
        m_rises = 0;
    endtask

    task automatic model_step(input logic start, input logic stop, input logic [3:0] div);
        if (rst || stop) begin
            model_clear();
        end else if (start) begin
            model_clear();
            m_mode = 1;
        end else if (m_mode != 0) begin
            if (m_div == int'(div)) begin
                m_div  = 0;
                m_pclk = 1 - m_pclk;
                if (m_mode == 1 && m_pclk == 1) m_rises++;
                else if (m_mode == 1 && m_pclk == 0 && m_rises == RST_CYCLES) m_mode = 2;
            end else begin
                m_div = (m_div + 1) % 16;
            end
        end
    endtask

    function automatic logic [43:0] expect_vec();
        logic        e_ena;
        logic        e_run;
        logic [17:0] e_iw;
        logic [23:0] e_ret;
        e_ena = (m_mode != 0);
        e_run = (m_mode == 2);
        e_iw  = e_ena ? {uio_in, ui_in, e_run, m_pclk[0]} : 18'd0;
        e_ret = e_run ? ow : 24'd0;
        return {e_ena, e_iw, e_ret, e_run};
    endfunction

    task automatic step(input logic start, input logic stop, input logic [3:0] div,
                        input logic [7:0] ui, input logic [7:0] uio, input logic [23:0] owv);
        @(negedge clk);
        cmd_start = start;
        cmd_stop  = stop;
        clk_div   = div;
        ui_in     = ui;
        uio_in    = uio;
        ow        = owv;
        model_step(start, stop, div);
        exp_q.push_back({start && !stop && !rst, expect_vec()});
    endtask

    task automatic rand_step(input logic start, input logic stop, input logic [3:0] div);
        step(start, stop, div, 8'($urandom), 8'($urandom), 24'($urandom));
    endtask

    // Monitor: per-cycle compare plus slot-level reset-release properties.
    logic [17:0] prev_iw  = '0;
    logic        prev_ena = 1'b0;
    int          mon_rises = 0;

    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", 64'(observed()), 64'(e[43:0]));
                if (e[44] || !ena) mon_rises = 0;
                else if (!iw[1] && iw[0] && !prev_iw[0]) mon_rises++;
                if (ena && prev_ena && iw[1] && !prev_iw[1]) begin
                    check("rst_n_on_pclk_fall", 64'({prev_iw[0], iw[0], running}), 64'(3'b101));
                    check("rst_low_rises", 64'(mon_rises), 64'(RST_CYCLES));
                end
                prev_iw  = iw;
                prev_ena = ena;
            end
        end
    end

    initial begin
        int guard;
        int r;
        logic [3:0] div;
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; clk_div = 4'd0;
        ui_in = 8'd0; uio_in = 8'd0; ow = 24'd0;
        #1;
        check("reset_state", 64'(observed()), 64'd0);
        repeat (3) rand_step(1'b0, 1'b0, 4'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) rand_step(1'b0, 1'b0, 4'd1);

        // Start with clk_div=1 and run into RUN.
        rand_step(1'b1, 1'b0, 4'd1);
        repeat (40) rand_step(1'b0, 1'b0, 4'd1);
        check("in_run_after_start", 64'(m_mode), 64'd2);
        step(1'b0, 1'b0, 4'd1, 8'hA5, 8'h3C, 24'hFF8142);
        step(1'b0, 1'b0, 4'd1, 8'hA5, 8'h3C, 24'hFF8142);

        // Start and stop together: stop wins.
        rand_step(1'b1, 1'b1, 4'd1);
        repeat (3) rand_step(1'b0, 1'b0, 4'd1);

        // Restart in the middle of the reset sequence.
        rand_step(1'b1, 1'b0, 4'd1);
        repeat (19) rand_step(1'b0, 1'b0, 4'd1);
        rand_step(1'b1, 1'b0, 4'd1);
        repeat (40) rand_step(1'b0, 1'b0, 4'd1);

        // Lower clk_div from 15 to 0 while the divider is mid-count.
        repeat (25) rand_step(1'b0, 1'b0, 4'd15);
        repeat (30) rand_step(1'b0, 1'b0, 4'd0);

        // Asynchronous reset while running; no auto-restart afterwards.
        guard = 0;
        while (m_mode != 2 && guard < 200) begin
            rand_step(1'b0, 1'b0, 4'd1);
            guard++;
        end
        check("run_before_async_rst", 64'(m_mode), 64'd2);
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_clears", 64'(observed()), 64'd0);
        model_clear();
        repeat (2) rand_step(1'b0, 1'b0, 4'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) rand_step(1'b0, 1'b0, 4'd2);

        // Random traffic.
        div = 4'd1;
        repeat (900) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 39) == 0)
                div = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            rand_step(r < 2, r >= 98, div);
        end

        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
